// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package ifu_fetch_pkg;

    localparam int unsigned CpuWidth  = 64;
    localparam int unsigned InstWidth = 32;

    localparam logic [CpuWidth-1:0] ResetPc = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        StReq,
        StWait,
        StHold
    } fetch_state_e;

    function automatic logic [CpuWidth-1:0] word_align(input logic [CpuWidth-1:0] addr);
        return {addr[CpuWidth-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-stage bus: imem request/response, IF/ID handoff and BRU feedback.
interface ifu_fetch_if;

    logic                                  imem_req_valid;
    logic                                  imem_req_ready;
    logic [ifu_fetch_pkg::CpuWidth-1:0]    imem_addr;
    logic                                  imem_rsp_valid;
    logic [ifu_fetch_pkg::InstWidth-1:0]   imem_rsp_data;
    logic                                  ifu_valid;
    logic                                  idu_ready;
    logic [ifu_fetch_pkg::CpuWidth-1:0]    ifu_pc;
    logic [ifu_fetch_pkg::InstWidth-1:0]   ifu_inst;
    logic [ifu_fetch_pkg::CpuWidth-1:0]    next_pc;
    logic                                  redirect;

    modport master (
        output imem_req_valid, imem_addr, ifu_valid, ifu_pc, ifu_inst,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, idu_ready, next_pc, redirect
    );

    modport slave (
        input  imem_req_valid, imem_addr, ifu_valid, ifu_pc, ifu_inst,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, idu_ready, next_pc, redirect
    );

endinterface

// File: rtl/ifu_fetch_buf.sv
// One-entry instruction holding register with load and clear.
module ifu_fetch_buf
    import ifu_fetch_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic                 clear_i,
    input  logic [InstWidth-1:0] data_i,
    output logic                 valid_o,
    output logic [InstWidth-1:0] data_o
);

    logic                 valid_q;
    logic [InstWidth-1:0] data_q;

    // Clearing only drops valid; the data stays visible on the output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the fetch PC, one outstanding imem request at a time.
module ifu_fetch
    import ifu_fetch_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    ifu_fetch_if.master bus
);

    fetch_state_e        state_q;
    logic [CpuWidth-1:0] pc_q;
    logic                drop_q;

    logic                buf_load;
    logic                buf_clear;
    logic                buf_valid;
    logic [InstWidth-1:0] buf_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StReq;
            pc_q    <= ResetPc;
            drop_q  <= 1'b0;
        end else begin
            if (bus.redirect) pc_q <= bus.next_pc;
            unique case (state_q)
                StReq: begin
                    if (bus.imem_req_ready) begin
                        state_q <= StWait;
                        drop_q  <= bus.redirect;
                    end
                end
                StWait: begin
                    if (bus.imem_rsp_valid) begin
                        drop_q  <= 1'b0;
                        state_q <= (drop_q || bus.redirect) ? StReq : StHold;
                    end else if (bus.redirect) begin
                        drop_q <= 1'b1;
                    end
                end
                StHold: begin
                    if (bus.redirect) begin
                        state_q <= StReq;
                    end else if (bus.idu_ready) begin
                        pc_q    <= bus.next_pc;
                        state_q <= StReq;
                    end
                end
                default: state_q <= StReq;
            endcase
        end
    end

    assign buf_load  = (state_q == StWait) && bus.imem_rsp_valid && !drop_q && !bus.redirect;
    assign buf_clear = (state_q == StHold) && (bus.redirect || bus.idu_ready);

    ifu_fetch_buf u_fetch_buf (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .data_i  (bus.imem_rsp_data),
        .valid_o (buf_valid),
        .data_o  (buf_data)
    );

    // A redirect squashes the held instruction in the same cycle.
    assign bus.imem_req_valid = (state_q == StReq) && !i_rst;
    assign bus.imem_addr      = word_align(pc_q);
    assign bus.ifu_valid      = buf_valid && !bus.redirect && !i_rst;
    assign bus.ifu_pc         = pc_q;
    assign bus.ifu_inst       = buf_data;

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction-fetch stage that owns the architectural fetch PC. It sits directly upstream of the branch-resolution unit: its PC drives the BRU's IF-PC input, and it consumes the BRU's next-PC and IF/ID-kill outputs.
- Issues one outstanding request at a time to instruction memory over a valid/ready handshake.
- Holds the returned instruction in a 1-entry buffer until the ID stage accepts it.
- Discards stale fetches on redirect.

Parameters:
CPU_WIDTH, 64, PC/address width (matches the shared CPU width constant)
INST_WIDTH, 32, instruction width
RESET_PC, 64'h0000_0000_8000_0000, PC value after reset

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  synchronous, active-high reset
i_next_pc  in  CPU_WIDTH  next PC from BRU (seq PC = o_ifu_pc+4, or redirect target)
i_redirect  in  1  BRU jump/kill (IF/ID nop): current IF contents are wrong-path
o_imem_req_valid  out  1  fetch request valid
i_imem_req_ready  in  1  imem accepts request
o_imem_addr  out  CPU_WIDTH  fetch address, bits[1:0] forced 0
i_imem_rsp_valid  in  1  response data valid (one cycle pulse)
i_imem_rsp_data  in  INST_WIDTH  fetched instruction
o_ifu_valid  out  1  instruction valid to IF/ID
i_idu_ready  in  1  ID stage accepts instruction
o_ifu_pc  out  CPU_WIDTH  PC of current fetch/held instruction
o_ifu_inst  out  INST_WIDTH  held instruction

Behaviour:
- Reset (sync, i_rst=1 at posedge):
  - State goes to REQ; pc = RESET_PC; drop flag cleared; inst buffer cleared to 0.
  - Outputs during and after reset: o_ifu_valid=0, o_imem_req_valid=0 while i_rst=1.
  - o_ifu_pc=RESET_PC, o_ifu_inst=0.
  - Reset mid-transaction abandons it; any later rsp is ignored because drop=1 is set on reset exit only if a request was accepted. Rule: a rsp arriving in REQ state is always ignored.
- FSM states: REQ, WAIT, HOLD.
  - REQ: o_imem_req_valid=1, addr={pc[CPU_WIDTH-1:2],2'b00}. valid&ready -> WAIT.
  - WAIT: wait i_imem_rsp_valid.
    - drop=0: capture data into buffer -> HOLD.
    - drop=1: discard, clear drop -> REQ.
  - HOLD: o_ifu_valid=1 (unless i_redirect). Handshake o_ifu_valid&i_idu_ready: pc<=i_next_pc -> REQ.
- Redirect (i_redirect=1), has priority over all other events in the same cycle:
  - pc<=i_next_pc in any state.
  - HOLD: buffer invalidated, o_ifu_valid forced 0 combinationally that cycle -> REQ.
  - WAIT (rsp not yet arrived): set drop -> WAIT. If rsp arrives the same cycle, discard it -> REQ.
  - REQ: a request accepted that cycle (valid&ready) goes to WAIT with drop=1. Otherwise stay REQ with the new pc.
- Latency: with a zero-wait imem (ready=1, rsp next cycle) and idu_ready=1, one instruction every 3 cycles (REQ, WAIT, HOLD). No fetch pipelining in this block.
- o_imem_addr and o_ifu_pc are stable while req_valid=1 and not accepted (AXI-style: no drop of valid without redirect). Redirect may change the address while req_valid is high.
- PC arithmetic is wrap-around modulo 2^CPU_WIDTH. i_next_pc is taken as-is; misalignment is not checked here.
- At most one request outstanding; rsp_valid outside WAIT is ignored.

Decomposition:
- Shared package: fetch-state enum {REQ,WAIT,HOLD}, RESET_PC constant, CPU_WIDTH/INST_WIDTH.
- One natural sub-module: fetch_buf, a 1-entry instruction holding register with valid/flush, built on the standard enabled-register primitive.

Test Plan:
- Reset release, imem ready=1, rsp 1 cycle later with 32'h00000013, idu_ready=1 -> req addr 0x80000000; o_ifu_valid with inst 0x13, pc 0x80000000; next req addr 0x80000004.
- idu_ready=0 for 5 cycles in HOLD -> o_ifu_valid stays 1, pc/inst stable, no new req; accept on cycle 6 -> next req at i_next_pc.
- Redirect in WAIT to 0x80000100, rsp 2 cycles later -> response discarded, o_ifu_valid never 1 for it; next req addr 0x80000100.
- Redirect in HOLD same cycle as idu_ready=1 -> o_ifu_valid=0, no handshake; req addr = redirect target.
- req_ready low 4 cycles -> req_valid held, addr stable; i_rst asserted mid-WAIT then late rsp -> ignored, req restarts at 0x80000000.
- pc=64'hFFFF_FFFF_FFFF_FFFC with i_next_pc=0 (wrapped seq) -> next req addr 0.
